// File: rtl/fpu_seq.sv
//==============================================================================
// Module      : fpu_seq
// Description : Sequencer feeding a register file through an external
//               multi-cycle FP unit. Optional macro FPU_SEQ_STICKY_FLAGS_EN
//               makes the exception flags accumulate across operations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_seq #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8,
    parameter int LAT_SQR = 8,
    parameter int LAT_CMP = 2,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [2:0]        cmd_round,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              unit_start,
    output logic [2:0]        unit_op,
    output logic [2:0]        unit_round,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    input  logic [DATA_W-1:0] unit_result,
    input  logic [4:0]        unit_flags,
    input  logic [2:0]        unit_cmp,
    output logic              done,
    output logic              busy,
    output logic [4:0]        flags,
    input  logic              flag_clr,
    output logic              less,
    output logic              eq,
    output logic              great
);

    localparam logic [4:0] C_FLAG_INV = 5'b10000;
    localparam logic [2:0] C_OP_SQRT  = 3'd3;
    localparam logic [2:0] C_OP_CMP   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic [2:0]        r_round;
    logic [ADDR_W-1:0] r_src1;
    logic [ADDR_W-1:0] r_src2;
    logic [ADDR_W-1:0] r_dst;
    logic [15:0]       r_cnt;
    logic [15:0]       w_lat;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_uflags;
    logic [2:0]        r_ucmp;
    logic [4:0]        r_flags;
    logic              r_less;
    logic              r_eq;
    logic              r_great;
    logic [4:0]        w_wb_flags;
    logic              w_accept;
    logic              w_illegal;
    logic              w_sample;
    logic [DATA_W-1:0] r_rf [NREGS];

    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_illegal  = (r_op > C_OP_CMP);
    assign w_sample   = (r_state == S_WAIT) && (r_cnt == w_lat);
    assign w_wb_flags = w_illegal ? C_FLAG_INV : r_uflags;

    always_comb begin
        w_lat = 16'd1;
        case (r_op)
            3'd0:    w_lat = 16'(LAT_ADD);
            3'd1:    w_lat = 16'(LAT_MUL);
            3'd2:    w_lat = 16'(LAT_DIV);
            3'd3:    w_lat = 16'(LAT_SQR);
            3'd4:    w_lat = 16'(LAT_CMP);
            default: w_lat = 16'd1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // Undefined opcodes bypass the unit entirely
                if (cmd_valid)
                    w_state_nxt = (cmd_op > C_OP_CMP) ? S_WB : S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_sample) w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstp)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            r_op     <= '0;
            r_round  <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_dst    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_uflags <= '0;
            r_ucmp   <= '0;
            r_flags  <= '0;
            r_less   <= 1'b0;
            r_eq     <= 1'b0;
            r_great  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_round <= cmd_round;
                r_src1  <= cmd_src1;
                r_src2  <= cmd_src2;
                r_dst   <= cmd_dst;
            end
            if (r_state == S_ISSUE)
                r_cnt <= 16'd1;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 16'd1;
            if (w_sample) begin
                r_result <= unit_result;
                r_uflags <= unit_flags;
                r_ucmp   <= unit_cmp;
            end
            // A writeback update takes priority over a coincident clear
            if (r_state == S_WB) begin
`ifdef FPU_SEQ_STICKY_FLAGS_EN
                r_flags <= r_flags | w_wb_flags;
`else
                r_flags <= w_wb_flags;
`endif
                if (r_op == C_OP_CMP) begin
                    r_less  <= r_ucmp[2];
                    r_eq    <= r_ucmp[1];
                    r_great <= r_ucmp[0];
                end
            end else if (flag_clr) begin
                r_flags <= '0;
            end
        end
    end

    // Register file is deliberately left out of reset
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && wr_en)
            r_rf[wr_addr] <= wr_data;
        else if ((r_state == S_WB) && !r_op[2] && !rstp)
            r_rf[r_dst] <= r_result;
    end

    // Operands are read live; the file cannot change between ISSUE and end of WB
    assign unit_a     = (r_state != S_IDLE) ? r_rf[r_src1] : '0;
    assign unit_b     = ((r_state != S_IDLE) && (r_op != C_OP_SQRT)) ? r_rf[r_src2] : '0;
    assign unit_op    = r_op;
    assign unit_round = r_round;
    assign unit_start = (r_state == S_ISSUE);
    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_WB);
    assign flags      = r_flags;
    assign less       = r_less;
    assign eq         = r_eq;
    assign great      = r_great;
    assign rd_data    = r_rf[rd_addr];

endmodule

`default_nettype wire

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32; operand, result and register width.
REQ-002 SHALL have parameter NREGS, default 32; register-file depth; ADDR_W = clog2(NREGS).
REQ-003 SHALL have parameters LAT_ADD=3, LAT_MUL=3, LAT_DIV=8, LAT_SQR=8, LAT_CMP=2; per-op unit latency in cycles, each >=1.
REQ-004 SHALL have the ports below, clock and reset first.
- clk  in  1  sole clock; all state changes on its rising edge.
- rstp  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  3  0=add, 1=mul, 2=div, 3=sqrt, 4=compare.
- cmd_src1, cmd_src2, cmd_dst  in  ADDR_W each  register addresses.
- cmd_round  in  3  rounding mode, forwarded to the unit.
- wr_en, wr_addr, wr_data  in  1/ADDR_W/DATA_W  host register write.
- rd_addr  in  ADDR_W; rd_data  out  DATA_W  combinational host read.
- unit_start  out  1  one-cycle start pulse to the FP unit.
- unit_op, unit_round  out  3 each; unit_a, unit_b  out  DATA_W each.
- unit_result  in  DATA_W; unit_flags  in  5  {inv,div_zero,ov,un,inexact}; unit_cmp  in  3  {less,eq,great}.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.
- flags  out  5  exception flags, same bit order as unit_flags.
- flag_clr  in  1  clears flags.
- less, eq, great  out  1 each  last compare result.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> WAIT -> WB -> IDLE.
REQ-006 cmd_ready SHALL equal (state==IDLE); acceptance latches op, src1, src2, dst and round.
REQ-007 In ISSUE, for exactly one cycle, SHALL drive unit_start=1, unit_a=reg[src1], unit_b=reg[src2] (unit_b=0 for sqrt); unit_a/unit_b/unit_op/unit_round SHALL hold until WB.
REQ-008 WAIT SHALL count LAT(op) cycles after the ISSUE cycle and SHALL sample unit_result/unit_flags/unit_cmp at the edge ending the LAT-th cycle.
REQ-009 For a command accepted at edge k, done SHALL be high during cycle k+2+LAT and cmd_ready SHALL be high again in cycle k+3+LAT.
REQ-010 Ops 0-3 SHALL write the sampled result to reg[dst] at the end of WB; op 4 SHALL NOT write the register file and SHALL update less/eq/great instead.
REQ-011 Opcodes 5-7 SHALL skip ISSUE/WAIT: go directly to WB, pulse done, set the inv flag, and perform no write; unit_start stays low.
REQ-012 Host writes SHALL occur only in IDLE; wr_en outside IDLE SHALL be ignored.
REQ-013 A host write and a command acceptance in the same IDLE cycle SHALL both take effect, and ISSUE SHALL read the newly written value.
REQ-014 src1==src2==dst SHALL be legal; operands are read in ISSUE, before the WB write.
REQ-015 flag_clr SHALL clear flags on the next edge; when coincident with a WB update, the WB update SHALL win.

Reset
REQ-016 rstp SHALL, at the next edge and from any state (including mid-WAIT), force IDLE and cancel any pending writeback.
REQ-017 rstp SHALL drive busy=0, done=0, unit_start=0, flags=0, less=eq=great=0, unit_a=unit_b=0, and cmd_ready=1 from the following cycle.
REQ-018 Register-file contents SHALL NOT be reset.

Configuration
REQ-019 Macro FPU_SEQ_STICKY_FLAGS_EN defined: each WB SHALL OR unit_flags into flags, which hold until flag_clr or rstp.
REQ-020 Macro FPU_SEQ_STICKY_FLAGS_EN undefined: each WB SHALL overwrite flags with that operation's flags.

Verification
REQ-021 Write reg1=0x3F800000 and reg2=0x40000000, issue add 1,2->3 with the stub unit returning 0x40400000 after 3 cycles -> done 5 cycles after accept; rd_addr=3 gives 0x40400000; unit_start pulsed once.
REQ-022 Div with LAT_DIV=8 and stub unit_flags=5'b01000 -> done at accept+10; flags=5'b01000; busy high for 10 cycles.
REQ-023 Compare with stub unit_cmp=3'b100 -> less=1, eq=great=0; destination register unchanged.
REQ-024 Opcode 6 -> done at accept+1, flags[4]=1, no unit_start pulse, no register write.
REQ-025 rstp asserted mid-WAIT of a mul -> next cycle IDLE, busy=0, no done pulse, reg[dst] keeps its old value.
REQ-026 Two ops with flags 5'b00001 then 5'b00100 -> 5'b00101 with FPU_SEQ_STICKY_FLAGS_EN defined, 5'b00100 without.
